cen_frac_gen: RTL and testbench

- Multi-channel fractional clock-enable generator for the simulation and core top levels. It replaces fixed-ratio divider instances.
- Each channel emits single-cycle enable pulses on clk_sys at an average rate of clk_sys*num/den.
- Ratios are reprogrammable at runtime. This lets the sim top switch between fast and cycle-accurate pixel rates without rebuilding.
- A global resync aligns all channel phases.

---
 rtl/cen_frac_gen.sv | 110 +++++++++++
 tb/tb_cen_frac_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cen_frac_gen.sv
`default_nettype none
// ============================================================================
// Module  : cen_frac_gen
// Brief   : Multi-channel fractional clock-enable generator. Channel k pulses
//           at an average rate of clk_sys*num_k/den_k (accumulator based).
//           The optional hold input is built in when the macro
//           CEN_FRAC_GEN_GATE_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module cen_frac_gen #(
  parameter  int CHANNELS = 2,
  parameter  int WIDTH    = 10,
  parameter  int DEF_NUM  = 1,
  parameter  int DEF_DEN  = 4,
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                cfg_wr,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_num,
  input  logic [WIDTH-1:0]    cfg_den,
  input  logic                resync,
`ifdef CEN_FRAC_GEN_GATE_EN
  input  logic                hold,
`endif
  output logic [CHANNELS-1:0] cen,
  output logic                cfg_err
);

  localparam logic [WIDTH-1:0] C_DEF_NUM = WIDTH'(DEF_NUM);
  localparam logic [WIDTH-1:0] C_DEF_DEN = WIDTH'(DEF_DEN);

  logic             w_hold;
  logic             w_ch_bad;
  logic             w_num_over;
  logic [WIDTH-1:0] w_num_clamp;
  logic             r_cfg_err;

`ifdef CEN_FRAC_GEN_GATE_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  // Out-of-range channel indices only exist when CHANNELS is not a power of 2.
  if (CHANNELS == (1 << CHW)) begin : g_ch_full
    assign w_ch_bad = 1'b0;
  end else begin : g_ch_part
    assign w_ch_bad = (cfg_ch >= CHW'(CHANNELS));
  end

  assign w_num_over  = (cfg_num > cfg_den);
  assign w_num_clamp = w_num_over ? cfg_den : cfg_num;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_wr && (w_ch_bad || w_num_over);
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   w_sum;
    logic             w_sel;
    logic             r_cen;

    assign w_sel = cfg_wr && (cfg_ch == CHW'(k));
    // acc < den and num <= den always hold, so the sum fits in WIDTH+1 bits.
    assign w_sum = r_acc + {1'b0, r_num};

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_num <= C_DEF_NUM;
        r_den <= C_DEF_DEN;
        r_acc <= '0;
        r_cen <= 1'b0;
      end else if (w_sel) begin
        r_num <= w_num_clamp;
        r_den <= cfg_den;
        r_acc <= '0;
        r_cen <= 1'b0;
      end else if (resync) begin
        r_acc <= '0;
        r_cen <= 1'b0;
      end else if (w_hold) begin
        r_cen <= 1'b0;
      end else if (r_den == '0) begin
        r_acc <= '0;
        r_cen <= 1'b0;
      end else if (w_sum >= {1'b0, r_den}) begin
        r_acc <= w_sum - {1'b0, r_den};
        r_cen <= 1'b1;
      end else begin
        r_acc <= w_sum;
        r_cen <= 1'b0;
      end
    end

    assign cen[k] = r_cen;
  end

endmodule
`default_nettype wire

// File: tb/tb_cen_frac_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_cen_frac_gen
// Brief   : Self-checking bench for cen_frac_gen against a phase-count model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cen_frac_gen;

  localparam int CH  = 3;
  localparam int W   = 10;
  localparam int CHW = 2;
`ifdef CEN_FRAC_GEN_GATE_EN
  localparam bit HAS_HOLD = 1'b1;
`else
  localparam bit HAS_HOLD = 1'b0;
`endif

  logic           clk_sys = 1'b0;
  logic           reset   = 1'b1;
  logic           cfg_wr  = 1'b0;
  logic [CHW-1:0] cfg_ch  = '0;
  logic [W-1:0]   cfg_num = '0;
  logic [W-1:0]   cfg_den = '0;
  logic           resync  = 1'b0;
  logic           hold    = 1'b0;
  logic [CH-1:0]  cen;
  logic           cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: channel k has completed m_t[k] active ticks since its phase origin;
  // pulses emitted so far = floor(t*num/den), so a tick pulses when that grows.
  longint        m_num [CH];
  longint        m_den [CH];
  longint        m_t   [CH];
  logic [CH-1:0] exp_cen;
  logic          exp_err;
  int            pulses [CH];

  cen_frac_gen #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DEF_NUM  (1),
    .DEF_DEN  (4)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_num (cfg_num),
    .cfg_den (cfg_den),
    .resync  (resync),
`ifdef CEN_FRAC_GEN_GATE_EN
    .hold    (hold),
`endif
    .cen     (cen),
    .cfg_err (cfg_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_num[k] = 1;
      m_den[k] = 4;
      m_t[k]   = 0;
    end
    exp_cen = '0;
    exp_err = 1'b0;
  endtask

  task automatic model_update();
    exp_err = cfg_wr && ((int'(cfg_ch) >= CH) || (cfg_num > cfg_den));
    for (int k = 0; k < CH; k++) begin
      if (cfg_wr && int'(cfg_ch) == k) begin
        m_num[k]   = (cfg_num > cfg_den) ? longint'(cfg_den) : longint'(cfg_num);
        m_den[k]   = cfg_den;
        m_t[k]     = 0;
        exp_cen[k] = 1'b0;
      end else if (resync) begin
        m_t[k]     = 0;
        exp_cen[k] = 1'b0;
      end else if (HAS_HOLD && hold) begin
        exp_cen[k] = 1'b0;
      end else if (m_den[k] == 0) begin
        m_t[k]     = 0;
        exp_cen[k] = 1'b0;
      end else begin
        m_t[k]++;
        exp_cen[k] = ((m_t[k] * m_num[k]) / m_den[k]) != (((m_t[k] - 1) * m_num[k]) / m_den[k]);
      end
    end
  endtask

  // One clock edge: model follows the edge, outputs compared 1 time unit later,
  // then one-cycle strobes drop at the following falling edge.
  task automatic step();
    @(posedge clk_sys);
    model_update();
    #1;
    check("cen", cen, exp_cen);
    check("cfg_err", cfg_err, exp_err);
    for (int k = 0; k < CH; k++) if (cen[k]) pulses[k]++;
    @(negedge clk_sys);
    cfg_wr = 1'b0;
    resync = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input int ch, input int num, input int den);
    cfg_ch  = CHW'(ch);
    cfg_num = W'(num);
    cfg_den = W'(den);
    cfg_wr  = 1'b1;
    step();
  endtask

  task automatic defaults_after_release(input string tag);
    pulses = '{default: 0};
    for (int e = 1; e <= 12; e++) begin
      step();
      check(tag, cen, (e % 4 == 0) ? 64'd7 : 64'd0);
    end
  endtask

  initial begin
    int last;
    int first;
    int cyc;
    bit gap_ok;
    bit found;

    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_cen", cen, 0);
    check("rst_err", cfg_err, 0);
    @(negedge clk_sys);
    reset = 1'b0;

    // defaults 1/4: pulses on edges 4, 8, 12; 100 pulses in 400 cycles
    defaults_after_release("dflt_edge");
    run(388);
    check("dflt_cnt0", pulses[0], 100);
    check("dflt_cnt1", pulses[1], 100);

    // ch1 at 3/8
    write(1, 3, 8);
    pulses = '{default: 0};
    last   = -1;
    gap_ok = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      step();
      if (cen[1]) begin
        if (last >= 0 && !((i - last) == 2 || (i - last) == 3)) gap_ok = 1'b0;
        last = i;
      end
    end
    check("r38_cnt1", pulses[1], 300);
    check("r38_gap", gap_ok, 1);
    check("r38_cnt0", pulses[0], 200);

    // num == den, clamped write, den == 0
    write(0, 5, 5);
    for (int i = 0; i < 20; i++) begin
      step();
      check("full_high", cen[0], 1);
    end
    write(0, 9, 5);
    check("clamp_err", cfg_err, 1);
    step();
    check("clamp_err_clr", cfg_err, 0);
    check("clamp_high", cen[0], 1);
    write(0, 3, 0);
    pulses = '{default: 0};
    run(100);
    check("den0_cnt", pulses[0], 0);

    // resync aligns 1/3 and 1/4: first joint pulse at edge 12
    write(0, 1, 3);
    write(1, 1, 4);
    run(7);
    resync = 1'b1;
    step();
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (cen[0] && cen[1] && first == 0) first = e;
    end
    check("lcm_edge", first, 12);

    // out-of-range channel: ignored, error strobe
    write(3, 2, 2);
    check("badch_err", cfg_err, 1);
    step();
    check("badch_err_clr", cfg_err, 0);
    run(12);

    // randomized writes / resync / hold against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr  = 1'b1;
        cfg_ch  = CHW'($urandom_range(0, 3));
        cfg_den = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 12));
        cfg_num = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 14));
      end
      if ($urandom_range(0, 15) == 0) resync = 1'b1;
      if (HAS_HOLD) hold = ($urandom_range(0, 9) == 0);
      step();
    end
    hold = 1'b0;

    // asynchronous reset while a pulse is high
    write(0, 1, 4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (cen[0]) found = 1'b1;
    end
    check("arst_find", found, 1);
    reset = 1'b1;
    #1;
    check("arst_cen", cen, 0);
    model_reset();
    @(negedge clk_sys);
    reset = 1'b0;
    defaults_after_release("arst_edge");

`ifdef CEN_FRAC_GEN_GATE_EN
    write(0, 1, 4);
    pulses = '{default: 0};
    cyc    = 0;
    found  = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      cyc++;
      if (cen[0]) found = 1'b1;
    end
    check("hold_find", found, 1);
    run(2);
    cyc += 2;
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_cen0", cen[0], 0);
    end
    cyc += 10;
    hold = 1'b0;
    step();
    check("hold_rel1", cen[0], 0);
    step();
    check("hold_rel2", cen[0], 1);
    cyc += 2;
    while (cyc < 410) begin
      step();
      cyc++;
    end
    check("hold_total", pulses[0], 100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
